// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with valid/ready request and response.
// Optional DMEM_ALIGN_CHECK_EN: misaligned addresses fault instead of wrapping.
module dmem_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT =
      (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t      state, state_n;
   logic [3:0]  cnt;
   logic        started;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic [31:0] mem [DEPTH];

   logic          accept;
   logic          enter_resp;
   logic          op_we;
   logic          op_err;
   logic [31:0]   op_addr;
   logic [31:0]   op_wdata;
   logic [3:0]    op_be;
   logic [IW-1:0] op_idx;

   assign accept = req_valid && req_ready;

   // With zero wait states the access happens on the acceptance edge itself
   assign op_we    = (state == IDLE) ? req_we    : we_q;
   assign op_addr  = (state == IDLE) ? req_addr  : addr_q;
   assign op_wdata = (state == IDLE) ? req_wdata : wdata_q;
   assign op_be    = (state == IDLE) ? req_be    : be_q;
   assign op_idx   = op_addr[IW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
   assign op_err = (|op_addr[31:IW+2]) || (|op_addr[1:0]);
`else
   logic unused_lo;
   assign unused_lo = ^op_addr[1:0];
   assign op_err    = |op_addr[31:IW+2];
`endif

   assign enter_resp = (state != RESP) && (state_n == RESP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         started <= 1'b0;
      end else begin
         state   <= state_n;
         started <= 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (accept)
                  state_n = (LATENCY == 0) ? RESP : WAIT;
         WAIT: if (cnt == 4'd0)
                  state_n = RESP;
         RESP: if (resp_ready)
                  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = started && (state == IDLE);
      resp_valid = (state == RESP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= 4'd0;
         we_q       <= 1'b0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         be_q       <= 4'd0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
      end else begin
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
            cnt     <= CNT_INIT;
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_resp) begin
            resp_err   <= op_err;
            resp_rdata <= (!op_err && !op_we) ? mem[op_idx] : 32'd0;
         end else if (resp_valid && resp_ready) begin
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
         end
      end
   end

   // Storage is deliberately not reset
   always_ff @(posedge clk) begin
      if (enter_resp && op_we && !op_err) begin
         for (int i = 0; i < 4; i++) begin
            if (op_be[i])
               mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
         end
      end
   end

endmodule
